// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge transaction scheduler.
package apb2axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int TAG_W      = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // One committed descriptor as presented at the head of the directory.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic                  is_write;
  } dir_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_AR = 2'd1,
    ISSUE_AW = 2'd2
  } txn_sched_state_e;

endpackage

// File: rtl/apb2axi_credit_cnt.sv
// Outstanding-transaction counter for one AXI direction.
// Tracks issued-but-not-completed bursts, reports whether another may be
// issued, and latches a sticky flag if a completion arrives at zero.
module apb2axi_credit_cnt #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       inc,
  input  logic       dec,
  output logic       avail,
  output logic [3:0] cnt,
  output logic       underflow
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt_q, cnt_d;
  logic       uf_q, uf_d;

  // Next count: simultaneous issue and completion cancel out; a completion
  // at zero leaves the count at zero and raises the sticky flag.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 4'd1;
    end else if (dec && !inc) begin
      if (cnt_q == 4'd0) begin
        uf_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Count and sticky underflow registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= 4'd0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  // Credit is judged on the registered count only, so a completion in the
  // same cycle never unblocks the head early.
  assign avail     = (cnt_q < MAX_C);
  assign cnt       = cnt_q;
  assign underflow = uf_q;

endmodule

// File: rtl/apb2axi_txn_sched.sv
// Transaction scheduler: pops descriptors from the directory head in order,
// drops illegal bursts with an error pulse, and issues legal ones on AR/AW
// when the direction has outstanding credit.
// Optional statistics counters are built when APB2AXI_TXN_STATS_EN is defined.
module apb2axi_txn_sched
  import apb2axi_pkg::*;
#(
  parameter int AXI_DATA_W = 64,
  parameter int MAX_RD_OUT = 4,
  parameter int MAX_WR_OUT = 4
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  dir_pending_valid,
  input  dir_entry_t            dir_pending_entry,
  input  logic [TAG_W-1:0]      dir_pending_tag,
  output logic                  dir_pending_pop,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [TAG_W-1:0]      arid,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [TAG_W-1:0]      awid,
  input  logic                  rd_done_valid,
  input  logic                  wr_done_valid,
  output logic                  err_valid,
  output logic [TAG_W-1:0]      err_tag,
`ifdef APB2AXI_TXN_STATS_EN
  output logic [31:0]           stat_rd_issued,
  output logic [31:0]           stat_wr_issued,
  output logic [31:0]           stat_err,
  output logic [31:0]           stat_stall,
`endif
  output logic                  cnt_underflow,
  output logic [3:0]            rd_out_cnt,
  output logic [3:0]            wr_out_cnt
);

  localparam int AW1      = AXI_ADDR_W + 1;
  localparam int MAX_SIZE = $clog2(AXI_DATA_W / 8);

  txn_sched_state_e state_q, state_d;

  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [TAG_W-1:0]      id_q, id_d;

  logic       rd_inc, wr_inc;
  logic       rd_avail, wr_avail;
  logic       rd_uf, wr_uf;
  logic       size_ok, head_legal, head_credit;
  logic [AW1-1:0] span, page_end;

  // Burst legality of the head descriptor. Bytes touched = (len+1)<<size.
  // The burst stays in its 4KB page iff (page offset + bytes - 1) < 4096;
  // staying in the page also rules out wrapping past the top of the address
  // space, since the last page ends exactly at the top address.
  always_comb begin
    span       = (AW1'(dir_pending_entry.len) + AW1'(1)) << dir_pending_entry.size;
    page_end   = AW1'(dir_pending_entry.addr[11:0]) + span - AW1'(1);
    size_ok    = (dir_pending_entry.size <= 3'(MAX_SIZE));
    head_legal = size_ok && (page_end < AW1'(4096));
    head_credit = dir_pending_entry.is_write ? wr_avail : rd_avail;
  end

  // Scheduler FSM: decide pop/drop/issue in IDLE, hold payload until ready.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    size_d          = size_q;
    burst_d         = burst_q;
    id_d            = id_q;
    dir_pending_pop = 1'b0;
    err_valid       = 1'b0;
    rd_inc          = 1'b0;
    wr_inc          = 1'b0;
    case (state_q)
      IDLE: begin
        if (dir_pending_valid) begin
          if (!head_legal) begin
            dir_pending_pop = 1'b1;
            err_valid       = 1'b1;
          end else if (head_credit) begin
            dir_pending_pop = 1'b1;
            addr_d          = dir_pending_entry.addr;
            len_d           = dir_pending_entry.len;
            size_d          = dir_pending_entry.size;
            burst_d         = AXI_BURST_INCR;
            id_d            = dir_pending_tag;
            state_d         = dir_pending_entry.is_write ? ISSUE_AW : ISSUE_AR;
          end
        end
      end
      ISSUE_AR: begin
        if (arready) begin
          rd_inc  = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE_AW: begin
        if (awready) begin
          wr_inc  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must neither consume the head nor count an issue.
    if (preset) begin
      dir_pending_pop = 1'b0;
      err_valid       = 1'b0;
      rd_inc          = 1'b0;
      wr_inc          = 1'b0;
    end
  end

  // State and latched payload registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
    end
  end

  assign err_tag = err_valid ? dir_pending_tag : '0;

  assign arvalid = (state_q == ISSUE_AR);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = burst_q;
  assign arid    = id_q;

  assign awvalid = (state_q == ISSUE_AW);
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign awid    = id_q;

  apb2axi_credit_cnt #(.MAX(MAX_RD_OUT)) u_rd_cnt (
    .clk       (pclk),
    .srst      (preset),
    .inc       (rd_inc),
    .dec       (rd_done_valid),
    .avail     (rd_avail),
    .cnt       (rd_out_cnt),
    .underflow (rd_uf)
  );

  apb2axi_credit_cnt #(.MAX(MAX_WR_OUT)) u_wr_cnt (
    .clk       (pclk),
    .srst      (preset),
    .inc       (wr_inc),
    .dec       (wr_done_valid),
    .avail     (wr_avail),
    .cnt       (wr_out_cnt),
    .underflow (wr_uf)
  );

  assign cnt_underflow = rd_uf | wr_uf;

`ifdef APB2AXI_TXN_STATS_EN
  logic        stall;
  logic [3:0]  stat_evt;
  logic [127:0] stat_vec;

  // A stall is an IDLE cycle whose legal head is blocked only by credit.
  assign stall    = (state_q == IDLE) && dir_pending_valid && head_legal &&
                    !head_credit && !preset;
  assign stat_evt = {stall, err_valid, wr_inc, rd_inc};

  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [31:0] cnt_q, cnt_d;

    // Saturating event counter.
    always_comb begin
      cnt_d = cnt_q;
      if (stat_evt[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // Counter register, cleared on reset.
    always_ff @(posedge pclk) begin
      if (preset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stat_vec[gi*32 +: 32] = cnt_q;
  end

  assign stat_rd_issued = stat_vec[31:0];
  assign stat_wr_issued = stat_vec[63:32];
  assign stat_err       = stat_vec[95:64];
  assign stat_stall     = stat_vec[127:96];
`endif

endmodule
